// File: rtl/level_sequencer.sv
// level_sequencer
//   Game-flow controller for the falling-obstacle datapath. On frame ticks it
//   releases the ten blocks and three rectangles in level order, tracks each
//   object's lifetime through its end-of-fall flag, walks the game through
//   level one and level two, and counts elapsed game seconds.
//
// Ports
//   Clk          system clock
//   Reset        asynchronous active-low reset, clears all state
//   Run          one-cycle start/restart request (synchronous, wins over frame_tick)
//   frame_tick   one-cycle pulse per video frame
//   end_level    per-object finished-falling flags: [9:0] blocks, [12:10] rects
//   block_ready  per-block release/active flags
//   rect_ready   per-rectangle release/active flags
//   level_one    high in level one (run or drain)
//   level_two    high in level two (run or drain)
//   game_done    high after level two completes, until the next Run
//   seconds      elapsed game seconds, saturating at 1023
module level_sequencer #(
    parameter int FRAMES_PER_SEC = 60,
    parameter int L1_SPACING     = 90,
    parameter int L2_SPACING     = 45
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        frame_tick,
    input  logic [12:0] end_level,
    output logic [9:0]  block_ready,
    output logic [2:0]  rect_ready,
    output logic        level_one,
    output logic        level_two,
    output logic        game_done,
    output logic [9:0]  seconds
);

    localparam int SP_MAX = (L1_SPACING > L2_SPACING) ? L1_SPACING : L2_SPACING;
    localparam int SPW    = $clog2(SP_MAX + 1);
    localparam int FW     = $clog2(FRAMES_PER_SEC + 1);

    localparam logic [SPW-1:0] L1_LAST    = SPW'(L1_SPACING - 1);
    localparam logic [SPW-1:0] L2_LAST    = SPW'(L2_SPACING - 1);
    localparam logic [FW-1:0]  FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
    localparam logic [9:0]     SEC_MAX    = 10'd1023;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_L1_RUN   = 3'd1,
        S_L1_DRAIN = 3'd2,
        S_L2_RUN   = 3'd3,
        S_L2_DRAIN = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t           state_r;
    logic [12:0]      ready_r;
    logic [3:0]       slot_r;
    logic [SPW-1:0]   spc_r;
    logic [FW-1:0]    frame_r;
    logic [9:0]       seconds_r;
    logic             level_one_r;
    logic             level_two_r;
    logic             game_done_r;

    logic             in_l1_run_s;
    logic             in_run_s;
    logic             in_game_s;
    logic [3:0]       target_s;
    logic [SPW-1:0]   spacing_last_s;
    logic             last_slot_s;
    logic             release_s;
    logic [12:0]      release_mask_s;

    // Level-two release order: slot index -> object index (rects are 10..12).
    function automatic logic [3:0] l2_target(input logic [3:0] slot);
        logic [3:0] obj;
        case (slot)
            4'd0:    obj = 4'd0;
            4'd1:    obj = 4'd1;
            4'd2:    obj = 4'd2;
            4'd3:    obj = 4'd10;
            4'd4:    obj = 4'd3;
            4'd5:    obj = 4'd4;
            4'd6:    obj = 4'd5;
            4'd7:    obj = 4'd11;
            4'd8:    obj = 4'd6;
            4'd9:    obj = 4'd7;
            4'd10:   obj = 4'd8;
            4'd11:   obj = 4'd12;
            default: obj = 4'd9;
        endcase
        return obj;
    endfunction

    // Release qualification: which object is next and whether it may go this tick.
    always_comb begin
        in_l1_run_s = (state_r == S_L1_RUN);
        in_run_s    = (state_r == S_L1_RUN) || (state_r == S_L2_RUN);
        in_game_s   = in_run_s || (state_r == S_L1_DRAIN) || (state_r == S_L2_DRAIN);
        if (in_l1_run_s) begin
            target_s       = slot_r;
            spacing_last_s = L1_LAST;
            last_slot_s    = (slot_r == 4'd9);
        end else begin
            target_s       = l2_target(slot_r);
            spacing_last_s = L2_LAST;
            last_slot_s    = (slot_r == 4'd12);
        end
        // A still-active target stalls the release; the counter holds at its last value.
        release_s = frame_tick && in_run_s && (spc_r == spacing_last_s) && !ready_r[target_s];
        if (release_s) begin
            release_mask_s = 13'd1 << target_s;
        end else begin
            release_mask_s = 13'd0;
        end
    end

    // Game FSM, release scheduler, ready tracking and seconds counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r     <= S_IDLE;
            ready_r     <= 13'd0;
            slot_r      <= 4'd0;
            spc_r       <= {SPW{1'b0}};
            frame_r     <= {FW{1'b0}};
            seconds_r   <= 10'd0;
            level_one_r <= 1'b0;
            level_two_r <= 1'b0;
            game_done_r <= 1'b0;
        end else if (Run) begin
            // Restart from any state; a coincident frame_tick is dropped.
            state_r     <= S_L1_RUN;
            ready_r     <= 13'd0;
            slot_r      <= 4'd0;
            spc_r       <= L1_LAST;
            frame_r     <= {FW{1'b0}};
            seconds_r   <= 10'd0;
            level_one_r <= 1'b1;
            level_two_r <= 1'b0;
            game_done_r <= 1'b0;
        end else begin
            // Release only targets a zero bit, so set and clear never collide.
            ready_r <= (ready_r & ~end_level) | release_mask_s;

            if (in_game_s && frame_tick) begin
                if (frame_r == FRAME_LAST) begin
                    frame_r <= {FW{1'b0}};
                    if (seconds_r != SEC_MAX) begin
                        seconds_r <= seconds_r + 10'd1;
                    end
                end else begin
                    frame_r <= frame_r + FW'(1'b1);
                end
            end

            case (state_r)
                S_L1_RUN, S_L2_RUN: begin
                    if (frame_tick) begin
                        if (spc_r != spacing_last_s) begin
                            spc_r <= spc_r + SPW'(1'b1);
                        end else if (release_s) begin
                            spc_r  <= {SPW{1'b0}};
                            slot_r <= slot_r + 4'd1;
                            if (last_slot_s) begin
                                if (in_l1_run_s) begin
                                    state_r <= S_L1_DRAIN;
                                end else begin
                                    state_r <= S_L2_DRAIN;
                                end
                            end
                        end
                    end
                end
                S_L1_DRAIN: begin
                    // Registered ready bits: leaves the cycle after the last bit clears.
                    if (ready_r == 13'd0) begin
                        state_r     <= S_L2_RUN;
                        slot_r      <= 4'd0;
                        spc_r       <= L2_LAST;
                        level_one_r <= 1'b0;
                        level_two_r <= 1'b1;
                    end
                end
                S_L2_DRAIN: begin
                    if (ready_r == 13'd0) begin
                        state_r     <= S_DONE;
                        level_two_r <= 1'b0;
                        game_done_r <= 1'b1;
                    end
                end
                S_IDLE, S_DONE: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r     <= S_IDLE;
                    level_one_r <= 1'b0;
                    level_two_r <= 1'b0;
                    game_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign block_ready = ready_r[9:0];
    assign rect_ready  = ready_r[12:10];
    assign level_one   = level_one_r;
    assign level_two   = level_two_r;
    assign game_done   = game_done_r;
    assign seconds     = seconds_r;

endmodule

// File: tb/tb_level_sequencer.sv
// Testbench for level_sequencer. Main instance uses default parameters and a
// release scoreboard; a second instance with short timing parameters covers
// seconds saturation and asynchronous reset with objects in flight.
module tb_level_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst_n, run, frame_tick;
    logic [12:0] end_level;
    logic [9:0]  block_ready;
    logic [2:0]  rect_ready;
    logic        level_one, level_two, game_done;
    logic [9:0]  seconds;

    // short-parameter instance
    logic        s_rst_n, s_run, s_tick;
    logic [12:0] s_end;
    logic [9:0]  s_block;
    logic [2:0]  s_rect;
    logic        s_l1, s_l2, s_done;
    logic [9:0]  s_sec;

    level_sequencer u_dut (
        .Clk(clk), .Reset(rst_n), .Run(run), .frame_tick(frame_tick),
        .end_level(end_level), .block_ready(block_ready), .rect_ready(rect_ready),
        .level_one(level_one), .level_two(level_two), .game_done(game_done),
        .seconds(seconds)
    );

    level_sequencer #(.FRAMES_PER_SEC(2), .L1_SPACING(1), .L2_SPACING(1)) u_sat (
        .Clk(clk), .Reset(s_rst_n), .Run(s_run), .frame_tick(s_tick),
        .end_level(s_end), .block_ready(s_block), .rect_ready(s_rect),
        .level_one(s_l1), .level_two(s_l2), .game_done(s_done),
        .seconds(s_sec)
    );

    int tests = 0;
    int fails = 0;
    int tick_no = 0;

    typedef struct {
        int obj;
        int tick;
    } exp_t;
    exp_t sb_q[$];

    int l2_order[13] = '{0, 1, 2, 10, 3, 4, 5, 11, 6, 7, 8, 12, 9};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_release(input int obj, input int tick);
        exp_t e;
        e.obj  = obj;
        e.tick = tick;
        sb_q.push_back(e);
    endtask

    // Monitor: every newly set ready bit is one DUT release event.
    logic [12:0] prev_ready = 13'd0;
    always @(negedge clk) begin : monitor
        logic [12:0] cur;
        logic [12:0] nw;
        exp_t        e;
        cur = {rect_ready, block_ready};
        nw  = cur & ~prev_ready;
        for (int b = 0; b < 13; b++) begin
            if (nw[b]) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_release: object %0d at tick %0d, none expected", b, tick_no);
                end else begin
                    e = sb_q.pop_front();
                    check("release_obj", b, e.obj);
                    check("release_tick", tick_no, e.tick);
                end
            end
        end
        prev_ready <= cur;
    end

    task automatic do_run();
        run = 1'b1;
        @(posedge clk) #1;
        run = 1'b0;
        tick_no = 0;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        tick_no++;
        @(posedge clk) #1;
        frame_tick = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic pulse_end(input int idx);
        end_level = 13'd1 << idx;
        @(posedge clk) #1;
        end_level = 13'd0;
    endtask

    task automatic do_stick();
        s_tick = 1'b1;
        @(posedge clk) #1;
        s_tick = 1'b0;
        @(posedge clk) #1;
    endtask

    // Level one: releases at ticks 1+90i, each block cleared 10 ticks later; block 9 left active.
    task automatic run_l1();
        for (int t = 1; t <= 820; t++) begin
            if ((t - 1) % 90 == 0) expect_release((t - 1) / 90, t);
            if (t >= 11 && (t - 11) % 90 == 0) pulse_end((t - 11) / 90);
            do_tick();
            if (t == 600) check("l1_seconds_at_600", int'(seconds), 10);
        end
    endtask

    // Clear block 9 in L1_DRAIN; level two begins the cycle after it clears.
    task automatic finish_l1();
        check("l1_drain_level_one", int'(level_one), 1);
        check("l1_drain_level_two", int'(level_two), 0);
        check("l1_drain_ready", int'({rect_ready, block_ready}), 32'h200);
        check("l1_drain_seconds", int'(seconds), 13);
        pulse_end(9);
        @(negedge clk);
        check("b9_clear_ready", int'({rect_ready, block_ready}), 0);
        check("b9_clear_still_l1", int'(level_one), 1);
        check("b9_clear_not_l2", int'(level_two), 0);
        @(negedge clk);
        check("l2_entry_level_two", int'(level_two), 1);
        check("l2_entry_level_one", int'(level_one), 0);
        @(posedge clk) #1;
    endtask

    // Level two: release every 45 ticks, each object cleared right after release.
    task automatic run_l2(input int stop_slot);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) repeat (44) do_tick();
            expect_release(l2_order[k], tick_no + 1);
            do_tick();
            if (k == stop_slot) return;
            pulse_end(l2_order[k]);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0; run = 1'b0; frame_tick = 1'b0; end_level = 13'd0;
        s_rst_n = 1'b0; s_run = 1'b0; s_tick = 1'b0; s_end = 13'd0;
        #12;
        check("rst_ready", int'({rect_ready, block_ready}), 0);
        check("rst_level_one", int'(level_one), 0);
        check("rst_level_two", int'(level_two), 0);
        check("rst_game_done", int'(game_done), 0);
        check("rst_seconds", int'(seconds), 0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        s_rst_n = 1'b1;
        @(posedge clk) #1;

        // full game
        do_run();
        @(negedge clk);
        check("run_level_one", int'(level_one), 1);
        check("run_level_two", int'(level_two), 0);
        @(posedge clk) #1;
        run_l1();
        finish_l1();
        run_l2(13);
        @(negedge clk);
        check("l2_drain_level_two", int'(level_two), 1);
        check("l2_drain_not_done", int'(game_done), 0);
        @(negedge clk);
        check("done_game_done", int'(game_done), 1);
        check("done_level_two", int'(level_two), 0);
        check("done_level_one", int'(level_one), 0);
        check("done_seconds", int'(seconds), 22);
        @(posedge clk) #1;
        repeat (100) do_tick();
        check("done_seconds_frozen", int'(seconds), 22);
        check("done_still_done", int'(game_done), 1);

        // restart from DONE, then restart during L2_RUN with rect 1 active
        do_run();
        @(negedge clk);
        check("restart_done_level_one", int'(level_one), 1);
        check("restart_done_game_done", int'(game_done), 0);
        check("restart_done_seconds", int'(seconds), 0);
        @(posedge clk) #1;
        run_l1();
        finish_l1();
        run_l2(7);
        check("pre_restart_rect", int'(rect_ready), 2);
        check("pre_restart_block", int'(block_ready), 0);
        check("pre_restart_seconds", int'(seconds), 18);
        run = 1'b1;
        frame_tick = 1'b1;
        @(posedge clk) #1;
        run = 1'b0;
        frame_tick = 1'b0;
        tick_no = 0;
        @(negedge clk);
        check("restart_ready", int'({rect_ready, block_ready}), 0);
        check("restart_seconds", int'(seconds), 0);
        check("restart_level_one", int'(level_one), 1);
        check("restart_level_two", int'(level_two), 0);
        @(posedge clk) #1;
        expect_release(0, 1);
        do_tick();
        check("restart_first_release", int'(block_ready), 1);

        // short-parameter instance: saturation and async reset mid-L2
        s_run = 1'b1;
        @(posedge clk) #1;
        s_run = 1'b0;
        repeat (2300) do_stick();
        check("sat_seconds", int'(s_sec), 1023);
        check("sat_level_one", int'(s_l1), 1);
        check("sat_ready", int'({s_rect, s_block}), 32'h3FF);
        s_end = 13'h1FFF;
        @(posedge clk) #1;
        s_end = 13'd0;
        @(posedge clk) #1;
        check("sat_l2_entry", int'(s_l2), 1);
        repeat (3) do_stick();
        check("sat_l2_ready", int'({s_rect, s_block}), 7);
        check("sat_l2_seconds", int'(s_sec), 1023);
        #2;
        s_rst_n = 1'b0;
        #1;
        check("async_rst_ready", int'({s_rect, s_block}), 0);
        check("async_rst_flags", int'({s_l1, s_l2, s_done}), 0);
        check("async_rst_seconds", int'(s_sec), 0);
        @(posedge clk) #1;
        s_rst_n = 1'b1;
        @(posedge clk) #1;
        check("post_rst_idle", int'({s_l1, s_l2, s_done}), 0);
        s_run = 1'b1;
        @(posedge clk) #1;
        s_run = 1'b0;
        @(negedge clk);
        check("post_rst_run_level_one", int'(s_l1), 1);
        check("post_rst_run_ready", int'(s_block), 0);
        @(posedge clk) #1;
        do_stick();
        check("post_rst_first_release", int'(s_block), 1);

        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
